// File: rtl/fnd_scan_ctrl_if.sv
// Update bus between the led_fnd register bank and the FND scan controller.
// The master (register bank) presents a value/dp/brightness write. The slave
// (scan controller) returns the commit acknowledge and the frame-boundary pulse.
interface fnd_scan_ctrl_if;
  logic        val_wr;
  logic [15:0] val_data;
  logic [3:0]  dp_data;
  logic [3:0]  bright;
  logic        val_ack;
  logic        frame_done;

  modport master (
    output val_wr,
    output val_data,
    output dp_data,
    output bright,
    input  val_ack,
    input  frame_done
  );

  modport slave (
    input  val_wr,
    input  val_data,
    input  dp_data,
    input  bright,
    output val_ack,
    output frame_done
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// FND scan controller: time-multiplexes a 4-digit active-low 7-segment display.
// A prescaler/subphase/digit counter chain drives the anodes. Brightness is
// PWM over 16 subphases per digit slot. Value updates are staged in a pending
// register and committed to the displayed (shadow) copy only on frame
// boundaries, so a frame never mixes old and new digits.
// Optional build macro: FND_LZ_BLANK_EN enables leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  en,
  fnd_scan_ctrl_if.slave        upd,
  output logic [3:0]            an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  // Scan counters
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sub_q, sub_d;
  logic [1:0]    dig_q, dig_d;

  // Pending (staged) update
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    pend_bright_q, pend_bright_d;
  logic          pend_valid_q, pend_valid_d;

  // Shadow (displayed) copy
  logic [15:0]   shd_val_q, shd_val_d;
  logic [3:0]    shd_dp_q, shd_dp_d;
  logic [3:0]    shd_bright_q, shd_bright_d;

  // Registered outputs
  logic          val_ack_q, val_ack_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;

  logic          presc_wrap;
  logic          sub_wrap;
  logic          boundary;
  logic [3:0]    nib;
  logic [3:0]    lz_mask;

  // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Counter chain: prescaler -> subphase -> digit. Disabled display parks at 0.
  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    sub_wrap   = presc_wrap && (sub_q == 4'hF);
    boundary   = en && sub_wrap && (dig_q == 2'd3);
    presc_d    = '0;
    sub_d      = '0;
    dig_d      = '0;
    if (en) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
      sub_d   = presc_wrap ? sub_q + 4'd1 : sub_q;
      dig_d   = sub_wrap ? dig_q + 2'd1 : dig_q;
    end
  end

  // Update path: stage writes as pending; commit on the frame boundary.
  // A write landing exactly on the boundary bypasses the pending stage.
  always_comb begin
    pend_val_d    = pend_val_q;
    pend_dp_d     = pend_dp_q;
    pend_bright_d = pend_bright_q;
    pend_valid_d  = pend_valid_q;
    shd_val_d     = shd_val_q;
    shd_dp_d      = shd_dp_q;
    shd_bright_d  = shd_bright_q;
    val_ack_d     = 1'b0;
    frame_done_d  = boundary;
    if (upd.val_wr && boundary) begin
      shd_val_d    = upd.val_data;
      shd_dp_d     = upd.dp_data;
      shd_bright_d = upd.bright;
      pend_valid_d = 1'b0;
      val_ack_d    = 1'b1;
    end else begin
      if (upd.val_wr) begin
        pend_val_d    = upd.val_data;
        pend_dp_d     = upd.dp_data;
        pend_bright_d = upd.bright;
        pend_valid_d  = 1'b1;
      end
      if (boundary && pend_valid_q) begin
        shd_val_d    = pend_val_q;
        shd_dp_d     = pend_dp_q;
        shd_bright_d = pend_bright_q;
        pend_valid_d = 1'b0;
        val_ack_d    = 1'b1;
      end
    end
  end

  // Leading-zero mask: digit k>0 blanks when it and all higher nibbles are 0.
  always_comb begin
    lz_mask = 4'b0000;
`ifdef FND_LZ_BLANK_EN
    lz_mask[3] = (shd_val_d[15:12] == 4'h0);
    lz_mask[2] = (shd_val_d[15:8]  == 8'h00);
    lz_mask[1] = (shd_val_d[15:4]  == 12'h000);
`endif
  end

  // Display drive, computed from next-state counters/shadow so the committed
  // value shows on digit 0 at the same edge that val_ack rises.
  always_comb begin
    nib     = shd_val_d[{dig_d, 2'b00} +: 4];
    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (en) begin
      if (sub_d <= shd_bright_d) begin
        an_n_d[dig_d] = 1'b0;
      end
      seg_n_d = lz_mask[dig_d] ? 7'h7F : hex_to_seg(nib);
      dp_n_d  = ~shd_dp_d[dig_d];
    end
  end

  // Control, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      presc_q      <= '0;
      sub_q        <= '0;
      dig_q        <= '0;
      pend_valid_q <= 1'b0;
      shd_val_q    <= 16'h0000;
      shd_dp_q     <= 4'h0;
      shd_bright_q <= 4'hF;
      val_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      sub_q        <= sub_d;
      dig_q        <= dig_d;
      pend_valid_q <= pend_valid_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_bright_q <= shd_bright_d;
      val_ack_q    <= val_ack_d;
      frame_done_q <= frame_done_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
    end
  end

  // Pending data payload; only meaningful while pend_valid_q is set.
  always_ff @(posedge ACLK) begin
    pend_val_q    <= pend_val_d;
    pend_dp_q     <= pend_dp_d;
    pend_bright_q <= pend_bright_d;
  end

  assign upd.val_ack    = val_ack_q;
  assign upd.frame_done = frame_done_q;
  assign an_n           = an_n_q;
  assign seg_n          = seg_n_q;
  assign dp_n           = dp_n_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV=4 (64-cycle digit slot,
// 256-cycle frame). cyc counts rising edges since reset release.
module tb_fnd_scan_ctrl;
  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       en;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  int         cyc;
  int         checks = 0;
  int         errors = 0;
  int         cnt;
  int         acks;
  int         fds;

  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(.SCAN_DIV(4)) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .en     (en),
    .upd    (bus),
    .an_n   (an_n),
    .seg_n  (seg_n),
    .dp_n   (dp_n)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] br);
    bus.val_wr   = 1'b1;
    bus.val_data = v;
    bus.dp_data  = dp;
    bus.bright   = br;
    tick();
    bus.val_wr   = 1'b0;
  endtask

  task automatic count_an(input logic [3:0] pat, input int n, output int c);
    c = 0;
    repeat (n) begin
      if (an_n === pat) c++;
      tick();
    end
  endtask

  task automatic count_pulses(input int n, output int a, output int f);
    a = 0;
    f = 0;
    repeat (n) begin
      if (bus.val_ack === 1'b1) a++;
      if (bus.frame_done === 1'b1) f++;
      tick();
    end
  endtask

  initial begin
    ARESETN      = 1'b0;
    en           = 1'b1;
    bus.val_wr   = 1'b0;
    bus.val_data = 16'h0000;
    bus.dp_data  = 4'h0;
    bus.bright   = 4'h0;
    cyc          = 0;

    // Reset held with en=1
    repeat (5) tick();
    check("rst_an", 16'(an_n), 16'hF);
    check("rst_seg", 16'(seg_n), 16'h7F);
    check("rst_dp", 16'(dp_n), 16'h1);
    check("rst_ack", 16'(bus.val_ack), 16'h0);
    check("rst_fd", 16'(bus.frame_done), 16'h0);

    ARESETN = 1'b1;
    cyc = 0;
    tick();
    check("post_rst_an", 16'(an_n), 16'hE);
    check("post_rst_seg", 16'(seg_n), 16'h40);
    check("post_rst_dp", 16'(dp_n), 16'h1);

    // Load 1234, committed at the first frame boundary
    write(16'h1234, 4'h0, 4'hF);
    goto_cyc(255);
    check("pre_commit_an", 16'(an_n), 16'h7);
    check("pre_commit_seg", 16'(seg_n), 16'h40);
    check("pre_commit_fd", 16'(bus.frame_done), 16'h0);
    tick();
    check("commit_fd", 16'(bus.frame_done), 16'h1);
    check("commit_ack", 16'(bus.val_ack), 16'h1);
    check("commit_an", 16'(an_n), 16'hE);
    check("commit_seg_d0", 16'(seg_n), 16'h19);
    tick();
    check("fd_pulse_end", 16'(bus.frame_done), 16'h0);
    check("ack_pulse_end", 16'(bus.val_ack), 16'h0);

    // Scan order and decode
    goto_cyc(320);
    check("scan_an_d1", 16'(an_n), 16'hD);
    check("scan_seg_d1", 16'(seg_n), 16'h30);
    goto_cyc(384);
    check("scan_an_d2", 16'(an_n), 16'hB);
    check("scan_seg_d2", 16'(seg_n), 16'h24);
    goto_cyc(448);
    check("scan_an_d3", 16'(an_n), 16'h7);
    check("scan_seg_d3", 16'(seg_n), 16'h79);
    goto_cyc(512);
    check("frame2_fd", 16'(bus.frame_done), 16'h1);
    check("frame2_no_ack", 16'(bus.val_ack), 16'h0);
    count_an(4'hE, 256, cnt);
    check("d0_slot_len", 16'(cnt), 16'd64);

    // Tear-free update mid-frame
    goto_cyc(800);
    write(16'hABCD, 4'b0001, 4'hF);
    goto_cyc(900);
    check("tear_an_d2", 16'(an_n), 16'hB);
    check("tear_seg_d2", 16'(seg_n), 16'h24);
    goto_cyc(1023);
    check("tear_seg_d3", 16'(seg_n), 16'h79);
    check("tear_no_ack", 16'(bus.val_ack), 16'h0);
    tick();
    check("tear_ack", 16'(bus.val_ack), 16'h1);
    check("tear_fd", 16'(bus.frame_done), 16'h1);
    check("tear_seg_D", 16'(seg_n), 16'h21);
    check("tear_dp", 16'(dp_n), 16'h0);

    // Back-to-back writes: last one wins, one ack
    goto_cyc(1050);
    write(16'h1111, 4'h0, 4'hF);
    goto_cyc(1060);
    write(16'h2222, 4'h0, 4'hF);
    count_pulses(220, acks, fds);
    check("b2b_ack_count", 16'(acks), 16'd1);
    check("b2b_seg", 16'(seg_n), 16'h24);

    // Write in the boundary cycle commits immediately
    goto_cyc(1535);
    write(16'h5678, 4'h0, 4'hF);
    check("bnd_ack", 16'(bus.val_ack), 16'h1);
    check("bnd_seg", 16'(seg_n), 16'h00);
    tick();
    count_pulses(256, acks, fds);
    check("bnd_no_pending_ack", 16'(acks), 16'd0);
    check("bnd_fd_count", 16'(fds), 16'd1);

    // Brightness 3 and 0
    goto_cyc(1800);
    write(16'h5678, 4'h0, 4'h3);
    goto_cyc(2048);
    count_an(4'hE, 64, cnt);
    check("bright3_on", 16'(cnt), 16'd16);
    goto_cyc(2120);
    write(16'h5678, 4'h0, 4'h0);
    goto_cyc(2304);
    count_an(4'hE, 64, cnt);
    check("bright0_on", 16'(cnt), 16'd4);

    // Enable low mid-scan: blank, counters cleared, commit deferred
    goto_cyc(2400);
    en = 1'b0;
    tick();
    check("en0_an", 16'(an_n), 16'hF);
    check("en0_seg", 16'(seg_n), 16'h7F);
    check("en0_dp", 16'(dp_n), 16'h1);
    write(16'h9ABC, 4'h0, 4'hF);
    count_pulses(300, acks, fds);
    check("en0_no_ack", 16'(acks), 16'd0);
    check("en0_no_fd", 16'(fds), 16'd0);
    en = 1'b1;
    tick();
    check("en1_an", 16'(an_n), 16'hE);
    check("en1_seg", 16'(seg_n), 16'h00);
    goto_cyc(2958);
    check("en1_ack", 16'(bus.val_ack), 16'h1);
    check("en1_fd", 16'(bus.frame_done), 16'h1);
    check("en1_seg_C", 16'(seg_n), 16'h46);

    // Leading zeros: blanked only when the macro is defined
    goto_cyc(2970);
    write(16'h0050, 4'b1000, 4'hF);
    goto_cyc(3214);
    check("lz_ack", 16'(bus.val_ack), 16'h1);
    check("lz_seg_d0", 16'(seg_n), 16'h40);
    check("lz_dp_d0", 16'(dp_n), 16'h1);
    goto_cyc(3278);
    check("lz_an_d1", 16'(an_n), 16'hD);
    check("lz_seg_d1", 16'(seg_n), 16'h12);
    goto_cyc(3342);
    check("lz_an_d2", 16'(an_n), 16'hB);
`ifdef FND_LZ_BLANK_EN
    check("lz_seg_d2", 16'(seg_n), 16'h7F);
`else
    check("lz_seg_d2", 16'(seg_n), 16'h40);
`endif
    goto_cyc(3406);
    check("lz_an_d3", 16'(an_n), 16'h7);
`ifdef FND_LZ_BLANK_EN
    check("lz_seg_d3", 16'(seg_n), 16'h7F);
`else
    check("lz_seg_d3", 16'(seg_n), 16'h40);
`endif
    check("lz_dp_d3", 16'(dp_n), 16'h0);

    // Reset mid-frame discards a pending write
    goto_cyc(3420);
    write(16'h4321, 4'h0, 4'hF);
    goto_cyc(3430);
    ARESETN = 1'b0;
    tick();
    check("midrst_an", 16'(an_n), 16'hF);
    check("midrst_seg", 16'(seg_n), 16'h7F);
    check("midrst_ack", 16'(bus.val_ack), 16'h0);
    ARESETN = 1'b1;
    tick();
    check("midrst_rel_an", 16'(an_n), 16'hE);
    check("midrst_rel_seg", 16'(seg_n), 16'h40);
    goto_cyc(3687);
    check("midrst_fd", 16'(bus.frame_done), 16'h1);
    check("midrst_no_ack", 16'(bus.val_ack), 16'h0);
    check("midrst_seg_zero", 16'(seg_n), 16'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Scan controller for the 4-digit multiplexed 7-segment (FND) display driven by the led_fnd AXI4-Lite peripheral. It takes a 16-bit hex value, decimal-point mask and brightness level from the slave register bank, time-multiplexes the shared segment bus across the four digit anodes, and applies register updates only on frame boundaries so the display never shows a torn value. It sits between the AXI4-Lite register file and the FND pins, in the ACLK domain.

## Interface
- SCAN_DIV, 1024, ACLK cycles per brightness sub-phase; one digit slot is 16 sub-phases; must be ≥ 2
- ACLK  in  1  system clock
- ARESETN  in  1  synchronous, active-low reset
- en  in  1  display enable; 0 blanks all anodes and holds the scan counters at 0
- val_wr  in  1  single-cycle request to load val_data/dp_data/bright
- val_data  in  16  hex value; nibble k drives digit k (digit 0 = [3:0])
- dp_data  in  4  decimal-point enable per digit
- bright  in  4  brightness level, 0 = dimmest (1/16 on-time), 15 = full on
- val_ack  out  1  one-cycle pulse when the pending value is committed to the shadow registers
- frame_done  out  1  one-cycle pulse at each frame boundary (digit 3 → 0)
- an_n  out  4  digit anodes, active-low, one-hot-low or all-high
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low

## Operation
- Counters: prescaler 0..SCAN_DIV-1; subphase 0..15 increments when the prescaler wraps; digit index 0..3 increments when the subphase wraps, and wraps 3 → 0. A frame is 64·SCAN_DIV cycles.
- Frame boundary: the cycle in which the prescaler, subphase and digit are all at their terminal counts and en=1.
- Update path: val_wr captures {val_data, dp_data, bright} into the pending register and sets pending_valid. A second val_wr before commit overwrites the pending data (last write wins). At the frame boundary, if pending_valid, pending → shadow, pending_valid is cleared and val_ack is asserted.
- val_wr in the same cycle as the frame boundary commits the incoming data directly (bypass) and asserts val_ack in that cycle.
- Display: for the current digit d, an_n[d]=0 only while subphase ≤ shadow bright; otherwise all an_n=1. seg_n is the hex decode (0–F, standard a–g patterns) of shadow nibble d. dp_n = ~shadow dp[d].
- en=0: an_n=4'hF, seg_n=7'h7F, dp_n=1, all counters forced to 0, no frame_done. Pending capture and val_wr handling continue, but commit waits for a frame boundary after en returns to 1.

## Timing
- Reset values: an_n=4'hF, seg_n=7'h7F, dp_n=1, val_ack=0, frame_done=0; shadow value=0, shadow bright=15, pending_valid=0, all counters 0.
- All outputs are registered. an_n, seg_n and dp_n reflect counter and shadow state with one cycle of latency.
- val_ack and frame_done are asserted in the cycle after the frame-boundary cycle. The committed value appears on digit 0 at the same edge.
- Worst-case val_wr-to-display latency: 64·SCAN_DIV + 1 cycles.
- Deasserting ARESETN mid-frame returns all state to the reset values on the next ACLK edge. Any pending write is discarded.

## Configuration
- FND_LZ_BLANK_EN defined: leading-zero blanking. Any digit k>0 whose nibble and all higher nibbles are 0 drives seg_n=7'h7F. Its dp_n still follows dp_data. Digit 0 is always shown.
- FND_LZ_BLANK_EN undefined: every digit shows its nibble, including leading zeros.

## Test plan
- Reset and defaults: hold ARESETN=0 for 5 cycles with en=1 → an_n=F, seg_n=7F, dp_n=1. After release, digit 0 shows "0" (seg_n=7'h40) with full on-time.
- Scan order and decode, SCAN_DIV=4, val_data=16'h1234, bright=15 → an_n sequence E,D,B,7, each held 64 cycles. seg_n = 19 (4), 30 (3), 24 (2), 79 (1) on the respective digits. frame_done every 256 cycles.
- Tear-free update: val_wr with 16'hABCD mid-frame → display unchanged until the boundary. val_ack and frame_done pulse together, and digit 0 then shows D (seg_n=7'h21).
- Back-to-back writes: 16'h1111 then 16'h2222 before the boundary → exactly one val_ack, and 2222 is displayed. A write in the boundary cycle itself commits in that frame.
- Brightness: bright=3, SCAN_DIV=4 → each anode is low for 16 of its 64 slot cycles. bright=0 → low for 4 cycles.
- en and macro: with en=0 mid-scan → all blank and counters cleared. With FND_LZ_BLANK_EN and val_data=16'h0050 → digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0.
